rot_word_aligner: RTL and testbench

- Frame word aligner for the barrel-shift datapath.
- Hunts for the rotation amount that aligns a received word stream to a programmable sync pattern, then verifies and locks it.
- Once locked, outputs rotate-right-corrected words with a start-of-frame marker.
- Sits directly upstream of the downstream word consumers. It generates the rotate amount and applies the rotate-right itself, so the rotate and the control stay in one registered stage.

---
 rtl/rot_word_aligner.sv | 223 ++++++++++++++++++++++
 tb/tb_rot_word_aligner.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/rot_word_aligner.sv
// rot_word_aligner: frame word aligner for the barrel-shift datapath.
//
// The aligner searches for the rotate-right amount that turns the received
// word stream into the programmable sync pattern. It then checks that the
// pattern repeats at the frame boundary, and locks once it has seen enough
// consecutive repeats. While locked, it emits rotate-corrected words and
// marks each frame's sync word with out_sof. The rotate is applied here,
// next to the control, so that both sit in one registered stage.
//
// Optional build macro ALIGN_ERR_CNT_EN adds a saturating 16-bit count of
// boundary sync misses seen while locked (port err_cnt). Only rst clears
// this count.
module rot_word_aligner #(
    parameter int WIDTH      = 8,
    parameter int FRAME_LEN  = 4,
    parameter int LOCK_CNT   = 3,
    parameter int UNLOCK_CNT = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_vld,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [WIDTH-1:0]         sync_pat,
    output logic                     out_vld,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_sof,
    output logic                     locked,
    output logic [$clog2(WIDTH)-1:0] rot
`ifdef ALIGN_ERR_CNT_EN
    ,
    output logic [15:0]              err_cnt
`endif
);

    localparam int RW  = $clog2(WIDTH);
    localparam int WCW = $clog2(FRAME_LEN);
    localparam int GCW = $clog2(LOCK_CNT + 1);
    localparam int MCW = $clog2(UNLOCK_CNT + 1);

    localparam logic [WCW-1:0] WC_LAST = WCW'(FRAME_LEN - 1);
    localparam logic [WCW-1:0] WC_ONE  = WCW'(1);
    localparam logic [GCW-1:0] GC_ONE  = GCW'(1);
    localparam logic [GCW-1:0] GC_LOCK = GCW'(LOCK_CNT);
    localparam logic [MCW-1:0] MC_ONE  = MCW'(1);
    localparam logic [MCW-1:0] MC_OUT  = MCW'(UNLOCK_CNT);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCK   = 2'd2
    } state_t;

    // rotr(x, r)[i] = x[(i + r) mod WIDTH]: shifting the doubled word right
    // and keeping the low half gives the wrapped indexing.
    function automatic logic [WIDTH-1:0] rotr(input logic [WIDTH-1:0] x,
                                              input logic [RW-1:0]    r);
        logic [2*WIDTH-1:0] dbl;
        dbl = {x, x} >> r;
        return dbl[WIDTH-1:0];
    endfunction

    state_t             state_q, state_d;
    logic [WCW-1:0]     word_cnt_q, word_cnt_d;
    logic [GCW-1:0]     good_cnt_q, good_cnt_d;
    logic [MCW-1:0]     miss_cnt_q, miss_cnt_d;
    logic [RW-1:0]      rot_q, rot_d;

    logic               out_vld_q;
    logic [WIDTH-1:0]   out_data_q;
    logic               out_sof_q;
    logic               locked_q;

    logic [WIDTH-1:0]   rot_data;
    logic               match;
    logic               boundary;
    logic [WCW-1:0]     word_cnt_inc;
    logic [GCW-1:0]     good_cnt_inc;
    logic [MCW-1:0]     miss_cnt_inc;

`ifdef ALIGN_ERR_CNT_EN
    logic [15:0]        err_cnt_q, err_cnt_d;
`endif

    assign rot_data     = rotr(in_data, rot_q);
    assign match        = (rot_data == sync_pat);
    assign boundary     = (word_cnt_q == '0);
    assign word_cnt_inc = (word_cnt_q == WC_LAST) ? '0 : word_cnt_q + WC_ONE;
    assign good_cnt_inc = good_cnt_q + GC_ONE;
    assign miss_cnt_inc = miss_cnt_q + MC_ONE;

    // Next-state logic for the hunt / verify / lock sequencer. Only
    // valid words advance anything.
    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        good_cnt_d = good_cnt_q;
        miss_cnt_d = miss_cnt_q;
        rot_d      = rot_q;
`ifdef ALIGN_ERR_CNT_EN
        err_cnt_d  = err_cnt_q;
`endif
        if (in_vld) begin
            case (state_q)
                HUNT: begin
                    if (match) begin
                        // The matching word becomes word 0 of the frame.
                        state_d    = VERIFY;
                        good_cnt_d = GC_ONE;
                        word_cnt_d = WC_ONE;
                    end else begin
                        // Hold each rotation for a whole frame so that
                        // every word position is tried at that rotation.
                        word_cnt_d = word_cnt_inc;
                        if (word_cnt_q == WC_LAST) begin
                            rot_d = rot_q + 1'b1;
                        end
                    end
                end
                VERIFY: begin
                    word_cnt_d = word_cnt_inc;
                    if (boundary) begin
                        if (match) begin
                            good_cnt_d = good_cnt_inc;
                            if (good_cnt_inc == GC_LOCK) begin
                                state_d    = LOCK;
                                miss_cnt_d = '0;
                            end
                        end else begin
                            // A false candidate: move on to the next rotation.
                            state_d    = HUNT;
                            rot_d      = rot_q + 1'b1;
                            word_cnt_d = '0;
                            good_cnt_d = '0;
                        end
                    end
                end
                LOCK: begin
                    word_cnt_d = word_cnt_inc;
                    if (boundary) begin
                        if (match) begin
                            miss_cnt_d = '0;
                        end else begin
`ifdef ALIGN_ERR_CNT_EN
                            if (err_cnt_q != 16'hFFFF) begin
                                err_cnt_d = err_cnt_q + 16'd1;
                            end
`endif
                            miss_cnt_d = miss_cnt_inc;
                            if (miss_cnt_inc == MC_OUT) begin
                                // Keep rot: the link most likely slipped a
                                // word, not a bit, so the rotation stays valid.
                                state_d    = HUNT;
                                word_cnt_d = '0;
                                miss_cnt_d = '0;
                            end
                        end
                    end
                end
                default: begin
                    state_d    = HUNT;
                    word_cnt_d = '0;
                    good_cnt_d = '0;
                    miss_cnt_d = '0;
                end
            endcase
        end
    end

    // Control state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= HUNT;
            word_cnt_q <= '0;
            good_cnt_q <= '0;
            miss_cnt_q <= '0;
            rot_q      <= '0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            good_cnt_q <= good_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            rot_q      <= rot_d;
        end
    end

`ifdef ALIGN_ERR_CNT_EN
    // Saturating lock-miss counter; survives relock, cleared only by rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

    // Output stage: uses the state before this word's transition. As a
    // result, the locking word is not emitted, and the unlocking word is.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld_q  <= 1'b0;
            out_sof_q  <= 1'b0;
            out_data_q <= '0;
            locked_q   <= 1'b0;
        end else begin
            out_vld_q <= in_vld && (state_q == LOCK);
            out_sof_q <= in_vld && (state_q == LOCK) && boundary;
            if (in_vld) begin
                out_data_q <= rot_data;
            end
            locked_q <= (state_d == LOCK);
        end
    end

    assign out_vld  = out_vld_q;
    assign out_data = out_data_q;
    assign out_sof  = out_sof_q;
    assign locked   = locked_q;
    assign rot      = rot_q;

endmodule

// File: tb/tb_rot_word_aligner.sv
// Directed bench for rot_word_aligner (WIDTH=8, FRAME_LEN=4, LOCK_CNT=3,
// UNLOCK_CNT=2, sync 8'hA5, frames of {8'h2D, 0, 0, 0}).
// 8'h2D rotated right by 3 gives 8'hA5, so the aligner locks at rot = 3.
module tb_rot_word_aligner;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_vld;
    logic [7:0] in_data;
    logic [7:0] sync_pat;
    logic       out_vld;
    logic [7:0] out_data;
    logic       out_sof;
    logic       locked;
    logic [2:0] rot;
`ifdef ALIGN_ERR_CNT_EN
    logic [15:0] err_cnt;
`endif

    int n_chk = 0;
    int n_bad = 0;

    rot_word_aligner #(
        .WIDTH(8), .FRAME_LEN(4), .LOCK_CNT(3), .UNLOCK_CNT(2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_vld   (in_vld),
        .in_data  (in_data),
        .sync_pat (sync_pat),
        .out_vld  (out_vld),
        .out_data (out_data),
        .out_sof  (out_sof),
        .locked   (locked),
        .rot      (rot)
`ifdef ALIGN_ERR_CNT_EN
        ,
        .err_cnt  (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of input, then sample just after the edge.
    task automatic step(input logic v, input logic [7:0] d);
        in_vld  = v;
        in_data = d;
        @(posedge clk);
        #1;
    endtask

    // Expected rotated sync word after reset: rot is 0,1,2 for the first
    // three frames, then 3.
    function automatic logic [7:0] exp_sync(input int k);
        case (k)
            0:       return 8'h2D;
            4:       return 8'h96;
            8:       return 8'h4B;
            default: return 8'hA5;
        endcase
    endfunction

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_vld"},    32'(out_vld),  0);
        chk({tag, "_data"},   32'(out_data), 0);
        chk({tag, "_sof"},    32'(out_sof),  0);
        chk({tag, "_locked"}, 32'(locked),   0);
        chk({tag, "_rot"},    32'(rot),      0);
`ifdef ALIGN_ERR_CNT_EN
        chk({tag, "_err"},    32'(err_cnt),  0);
`endif
    endtask

    initial begin
        logic [7:0] d;
        logic [7:0] prev;
        logic       sync_ok;

        rst      = 1'b1;
        in_vld   = 1'b0;
        in_data  = 8'h00;
        sync_pat = 8'hA5;

        // Reset with idle input, then with valid input.
        step(0, 8'h00);
        step(0, 8'h00);
        chk_reset_vals("rst_idle");
        step(1, 8'h2D);
        chk_reset_vals("rst_vld");
        rst = 1'b0;

        // Continuous stream: lock, then single misses at words 28 and 36.
        for (int k = 0; k < 44; k++) begin
            sync_ok = (k % 4 == 0) && (k != 28) && (k != 36);
            d = sync_ok ? 8'h2D : 8'h00;
            step(1, d);
            if (k == 10) chk("hunt_rot2", 32'(rot), 2);
            if (k == 11) chk("hunt_rot3", 32'(rot), 3);
            if (k == 12) begin
                chk("match_rot", 32'(rot), 3);
                chk("match_unlocked", 32'(locked), 0);
            end
            if (k == 19) chk("pre_lock", 32'(locked), 0);
            if (k == 20) begin
                chk("lock_rise", 32'(locked), 1);
                chk("lock_word_not_out", 32'(out_vld), 0);
            end
            if (k >= 21) begin
                chk("lk_vld", 32'(out_vld), 1);
                chk("lk_data", 32'(out_data), sync_ok ? 'hA5 : 'h00);
                chk("lk_sof", 32'(out_sof), (k % 4 == 0) ? 1 : 0);
                chk("lk_locked", 32'(locked), 1);
            end
        end
`ifdef ALIGN_ERR_CNT_EN
        chk("err_two_single", 32'(err_cnt), 2);
`endif

        // Fresh start with idle gaps, then unlock and relock at rot 3.
        rst = 1'b1;
        step(0, 8'h00);
        rst = 1'b0;
        prev = 8'h00;
        for (int k = 0; k < 49; k++) begin
            for (int g = 0; g < k % 3; g++) begin
                step(0, 8'hFF);
                chk("gap_vld", 32'(out_vld), 0);
                chk("gap_hold", 32'(out_data), 32'(prev));
            end
            sync_ok = (k % 4 == 0) && (k != 28) && (k != 32);
            d = sync_ok ? 8'h2D : 8'h00;
            step(1, d);
            prev = sync_ok ? exp_sync(k) : 8'h00;
            chk("g_data", 32'(out_data), 32'(prev));
            if (k == 19) chk("g_pre_lock", 32'(locked), 0);
            if (k == 20) begin
                chk("g_lock_rise", 32'(locked), 1);
                chk("g_lock_word", 32'(out_vld), 0);
            end
            if (k == 21) chk("g_first_vld", 32'(out_vld), 1);
            if (k == 24) chk("g_sof", 32'(out_sof), 1);
            if (k == 28) begin
                chk("u_miss1_locked", 32'(locked), 1);
                chk("u_miss1_sof", 32'(out_sof), 1);
            end
            if (k == 32) begin
                chk("u_unlock", 32'(locked), 0);
                chk("u_last_vld", 32'(out_vld), 1);
                chk("u_last_sof", 32'(out_sof), 1);
                chk("u_rot_kept", 32'(rot), 3);
`ifdef ALIGN_ERR_CNT_EN
                chk("u_err_cnt", 32'(err_cnt), 2);
`endif
            end
            if (k == 33) chk("u_no_vld", 32'(out_vld), 0);
            if (k == 36) chk("re_match_rot", 32'(rot), 3);
            if (k == 43) chk("re_pre_lock", 32'(locked), 0);
            if (k == 44) begin
                chk("re_lock", 32'(locked), 1);
                chk("re_rot", 32'(rot), 3);
            end
            if (k == 45) chk("re_vld", 32'(out_vld), 1);
            if (k == 48) chk("re_sof", 32'(out_sof), 1);
        end

        // Reset while locked with a valid word present.
        rst = 1'b1;
        step(1, 8'h2D);
        chk_reset_vals("rst_mid");
        rst = 1'b0;
        step(0, 8'h00);
        chk_reset_vals("post_rst");

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
